sram_loader: RTL and testbench

Stream-to-SRAM loader for the tensor core's on-chip memories: it accepts a valid/ready word stream and writes it into consecutive `sram` addresses from a programmable base, wrapping within the address space. It is the write-side initiator of the `sram` port (`cs`/`we`/`addr`/`din`/`dout`) and fills vocabulary and weight SRAMs at run time instead of relying on an init file. It also reports a running checksum, with optional read-back verification.

---
 rtl/sram_loader.sv | 190 +++++++++++++++++++
 tb/tb_sram_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_loader.sv
// sram_loader: streams valid/ready words into consecutive SRAM addresses
// starting at a programmable base. The address wraps within the SRAM depth.
// It keeps a running checksum of the words it writes.
// Optional feature macro: SRAM_LOADER_VERIFY_EN. When it is defined, every
// nonzero load is followed by a read-back pass. That pass sums the SRAM
// contents and raises verify_err when the sum differs from the checksum.
module sram_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic                  verify_err
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;

`ifdef SRAM_LOADER_VERIFY_EN
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_VREAD, S_VCHK, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_DONE} state_t;
`endif

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   checksum_q, checksum_d;
  logic [ADDR_WIDTH:0]     lengthClamped;

`ifdef SRAM_LOADER_VERIFY_EN
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH:0]     len_q, len_d;
  logic [DATA_WIDTH-1:0]   vsum_q, vsum_d;
  logic                    readPending_q, readPending_d;
  logic                    verifyErr_q, verifyErr_d;
  logic [DATA_WIDTH-1:0]   finalSum;
`else
  logic                    unusedDout;
  assign unusedDout = ^sram_dout;
`endif

  // Oversized lengths are capped at one full pass over the SRAM.
  assign lengthClamped = (length > DEPTH_CNT) ? DEPTH_CNT : length;

  // State and datapath registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      checksum_q    <= '0;
`ifdef SRAM_LOADER_VERIFY_EN
      base_q        <= '0;
      len_q         <= '0;
      vsum_q        <= '0;
      readPending_q <= 1'b0;
      verifyErr_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      checksum_q    <= checksum_d;
`ifdef SRAM_LOADER_VERIFY_EN
      base_q        <= base_d;
      len_q         <= len_d;
      vsum_q        <= vsum_d;
      readPending_q <= readPending_d;
      verifyErr_q   <= verifyErr_d;
`endif
    end
  end

  // Next-state logic and SRAM/stream handshake. The SRAM strobes are combinational, so each accepted word is written in its own cycle.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    checksum_d = checksum_q;
    s_ready    = 1'b0;
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_din   = '0;
    done       = 1'b0;
`ifdef SRAM_LOADER_VERIFY_EN
    base_d        = base_q;
    len_d         = len_q;
    vsum_d        = vsum_q;
    readPending_d = readPending_q;
    verifyErr_d   = verifyErr_q;
    finalSum      = vsum_q + sram_dout;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d      = base_addr;
          cnt_d      = lengthClamped;
          checksum_d = '0;
`ifdef SRAM_LOADER_VERIFY_EN
          base_d      = base_addr;
          len_d       = lengthClamped;
          verifyErr_d = 1'b0;
`endif
          state_d    = (lengthClamped == '0) ? S_DONE : S_WRITE;
        end
      end

      S_WRITE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          sram_cs    = 1'b1;
          sram_we    = 1'b1;
          sram_din   = s_data;
          ptr_d      = ptr_q + ADDR_ONE;
          cnt_d      = cnt_q - CNT_ONE;
          checksum_d = checksum_q + s_data;
          if (cnt_q == CNT_ONE) begin
`ifdef SRAM_LOADER_VERIFY_EN
            ptr_d         = base_q;
            cnt_d         = len_q;
            vsum_d        = '0;
            readPending_d = 1'b0;
            state_d       = S_VREAD;
`else
            state_d       = S_DONE;
`endif
          end
        end
      end

`ifdef SRAM_LOADER_VERIFY_EN
      S_VREAD: begin
        sram_cs       = 1'b1;
        ptr_d         = ptr_q + ADDR_ONE;
        cnt_d         = cnt_q - CNT_ONE;
        readPending_d = 1'b1;
        if (readPending_q) begin
          vsum_d = vsum_q + sram_dout;
        end
        if (cnt_q == CNT_ONE) begin
          state_d = S_VCHK;
        end
      end

      S_VCHK: begin
        readPending_d = 1'b0;
        vsum_d        = finalSum;
        verifyErr_d   = (finalSum != checksum_q);
        state_d       = S_DONE;
      end
`endif

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign sram_addr = ptr_q;
  assign busy      = (state_q != S_IDLE);
  assign checksum  = checksum_q;
`ifdef SRAM_LOADER_VERIFY_EN
  assign verify_err = verifyErr_q;
`else
  assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_loader.sv
// tb_sram_loader: scoreboard bench for sram_loader with a behavioural SRAM.
// The stimulus process queues the expected SRAM writes and done pulses.
// A negedge monitor pops those entries and compares them against the DUT.
module tb_sram_loader;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef SRAM_LOADER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          sram_cs;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;
  logic          verify_err;

  logic [DW-1:0] mem [DEPTH];
  logic          clearMem;
  logic          corruptEn;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { int cyc; logic [DW-1:0] sum; logic err; } dn_t;
  wr_t wrQ[$];
  dn_t doneQ[$];

  int nVec = 0;
  int nMiss = 0;
  int cyc = 0;
  logic [DW-1:0] dataVec [DEPTH];
  wr_t monW;
  dn_t monD;

  sram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout),
    .busy(busy), .done(done), .checksum(checksum), .verify_err(verify_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to time the done pulse.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port SRAM, with a bench-side corruption hook on address 3.
  always @(posedge clk) begin
    if (clearMem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (corruptEn) mem[3] <= 8'hFF;
      if (sram_cs && sram_we) mem[sram_addr] <= sram_din;
    end
    if (sram_cs && !sram_we) sram_dout <= mem[sram_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every SRAM write and every done pulse against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (sram_cs && sram_we) begin
        if (wrQ.size() == 0) begin
          nVec++; nMiss++;
          $display("[TB] FAIL unexpected write: got addr %0h data %0h expected none", sram_addr, sram_din);
        end else begin
          monW = wrQ.pop_front();
          checkOutput("write addr", 32'(sram_addr), 32'(monW.addr));
          checkOutput("write data", 32'(sram_din), 32'(monW.data));
        end
      end
      if (sram_cs && !sram_we && !VERIFY) begin
        nVec++; nMiss++;
        $display("[TB] FAIL read strobe: got cs=1 we=0 expected no reads");
      end
      if (done) begin
        if (doneQ.size() == 0) begin
          nVec++; nMiss++;
          $display("[TB] FAIL unexpected done: got done=1 at cycle %0d expected none", cyc);
        end else begin
          monD = doneQ.pop_front();
          checkOutput("done cycle", 32'(cyc), 32'(monD.cyc));
          checkOutput("checksum at done", 32'(checksum), 32'(monD.sum));
          checkOutput("verify_err at done", 32'(verify_err), 32'(monD.err));
        end
      end
    end
  end

  task automatic setData(input logic [DW-1:0] first, input logic [DW-1:0] step);
    for (int i = 0; i < DEPTH; i++) dataVec[i] = first + DW'(i) * step;
  endtask

  // Run one load: queue expectations, pulse start, stream words, then wait for completion.
  task automatic applyStimulus(input logic [AW-1:0] base, input logic [AW:0] len,
                               input bit toggle, input bit glitch, input int abortAfter,
                               input bit corrupt);
    int n, nw, lastWrite, extra, s0, idx, k;
    logic [DW-1:0] sum;
    bit v;
    n  = (len > 5'd16) ? 16 : int'(len);
    nw = (abortAfter > 0) ? abortAfter : n;
    sum = '0;
    for (int i = 0; i < nw; i++) begin
      wrQ.push_back('{addr: base + AW'(i), data: dataVec[i]});
      sum = sum + dataVec[i];
    end
    @(negedge clk);
    base_addr = base;
    length    = len;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s0 = cyc;
    lastWrite = (n == 0) ? 0 : (toggle ? 2 * n - 1 : n);
    extra     = (VERIFY && n > 0) ? n + 1 : 0;
    if (abortAfter == 0)
      doneQ.push_back('{cyc: s0 + lastWrite + extra, sum: sum, err: corrupt});
    checkOutput("busy after start", 32'(busy), 32'd1);
    checkOutput("s_ready after start", 32'(s_ready), (n > 0) ? 32'd1 : 32'd0);
    checkOutput("checksum cleared", 32'(checksum), 32'd0);
    checkOutput("verify_err cleared", 32'(verify_err), 32'd0);
    idx = 0;
    k = 1;
    while (idx < nw && k < 200) begin
      v = toggle ? (k % 2 == 1) : 1'b1;
      s_valid = v;
      s_data  = dataVec[idx];
      if (glitch && k == 3) begin
        start = 1'b1;
        base_addr = 4'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (v) idx++;
      k++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    if (abortAfter > 0) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("rst busy", 32'(busy), 32'd0);
      checkOutput("rst s_ready", 32'(s_ready), 32'd0);
      checkOutput("rst cs/we", 32'({sram_cs, sram_we}), 32'd0);
      checkOutput("rst done", 32'(done), 32'd0);
      checkOutput("rst addr", 32'(sram_addr), 32'd0);
      checkOutput("rst din", 32'(sram_din), 32'd0);
      checkOutput("rst checksum", 32'(checksum), 32'd0);
      checkOutput("rst verify_err", 32'(verify_err), 32'd0);
      repeat (4) @(posedge clk);
      #1;
    end else begin
      if (corrupt) begin
        corruptEn = 1'b1;
        @(posedge clk); #1;
        corruptEn = 1'b0;
      end
      for (int t = 0; t < 100 && doneQ.size() != 0; t++) @(posedge clk);
      #1;
      if (doneQ.size() != 0) begin
        nVec++; nMiss++;
        $display("[TB] FAIL done timeout: got no done expected %0d pending", doneQ.size());
        doneQ.delete();
      end else begin
        checkOutput("busy after done", 32'(busy), 32'd0);
      end
    end
    checkOutput("writes outstanding", 32'(wrQ.size()), 32'd0);
    wrQ.delete();
  endtask

  initial begin
    rst = 1'b1; clearMem = 1'b1; corruptEn = 1'b0;
    start = 1'b0; base_addr = '0; length = '0; s_valid = 1'b0; s_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset outputs", 32'({s_ready, sram_cs, sram_we, busy, done, verify_err}), 32'd0);
    checkOutput("reset addr/din/sum", 32'({sram_addr, sram_din, checksum}), 32'd0);
    rst = 1'b0; clearMem = 1'b0;

    $display("[TB] basic load base 0 length 16 with start glitch");
    setData(8'h00, 8'h01);
    applyStimulus(4'd0, 5'd16, 1'b0, 1'b1, 0, 1'b0);
    checkOutput("basic checksum", 32'(checksum), 32'h78);
    for (int i = 0; i < DEPTH; i++) checkOutput("basic mem", 32'(mem[i]), i);

    $display("[TB] wrap base 14 length 4");
    dataVec[0] = 8'hA1; dataVec[1] = 8'hA2; dataVec[2] = 8'hA3; dataVec[3] = 8'hA4;
    applyStimulus(4'd14, 5'd4, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("wrap checksum", 32'(checksum), 32'h8A);
    checkOutput("wrap mem14", 32'(mem[14]), 32'hA1);
    checkOutput("wrap mem1", 32'(mem[1]), 32'hA4);

    $display("[TB] backpressure length 3");
    dataVec[0] = 8'h11; dataVec[1] = 8'h22; dataVec[2] = 8'h33;
    applyStimulus(4'd5, 5'd3, 1'b1, 1'b0, 0, 1'b0);
    checkOutput("bp checksum", 32'(checksum), 32'h66);

    $display("[TB] length 0");
    applyStimulus(4'd7, 5'd0, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("len0 checksum", 32'(checksum), 32'd0);

    $display("[TB] length 20 clamped");
    setData(8'h01, 8'h03);
    applyStimulus(4'd2, 5'd20, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("clamp mem2", 32'(mem[2]), 32'h01);
    checkOutput("clamp mem1", 32'(mem[1]), 32'h2E);

    $display("[TB] reset mid-load");
    setData(8'h40, 8'h01);
    applyStimulus(4'd0, 5'd10, 1'b0, 1'b0, 5, 1'b0);
    for (int i = 0; i < 5; i++) checkOutput("kept mem", 32'(mem[i]), 32'h40 + i);
    dataVec[0] = 8'h05; dataVec[1] = 8'h06;
    applyStimulus(4'd8, 5'd2, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("post-reset checksum", 32'(checksum), 32'h0B);

`ifdef SRAM_LOADER_VERIFY_EN
    $display("[TB] verify with corrupted address 3");
    setData(8'h00, 8'h01);
    applyStimulus(4'd0, 5'd16, 1'b0, 1'b0, 0, 1'b1);
    checkOutput("verify_err held", 32'(verify_err), 32'd1);
    dataVec[0] = 8'h09;
    applyStimulus(4'd4, 5'd1, 1'b0, 1'b0, 0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
